// File: rtl/pll_cfg_pkg.sv
// Shared constants and FSM state type for the PLL dynamic-configuration controller.
// PLL_CFG_READBACK_EN adds the READ/CMP states used for write verification.
package pll_cfg_pkg;

  localparam logic [1:0] MD_NOP     = 2'b00;
  localparam logic [1:0] MD_WRITE   = 2'b01;
  localparam logic [1:0] MD_READ    = 2'b10;
  localparam logic [1:0] MD_SETADDR = 2'b11;

  localparam logic [1:0] STAT_OK           = 2'b00;
  localparam logic [1:0] STAT_BAD_ARG      = 2'b01;
  localparam logic [1:0] STAT_LOCK_TIMEOUT = 2'b10;
  localparam logic [1:0] STAT_RB_MISMATCH  = 2'b11;

  localparam logic [7:0] DIV_MIN = 8'd2;
  localparam logic [7:0] DIV_MAX = 8'd128;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHECK,
    S_SETADDR,
    S_WRITE,
`ifdef PLL_CFG_READBACK_EN
    S_READ,
    S_CMP,
`endif
    S_PRST,
    S_WLOCK,
    S_RESP
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level signal.
module sync_2ff (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_dyn_cfg_ctrl.sv
// Runtime ODIV reprogramming for a GW5A PLLA over its MD port: write, reset, wait for lock, respond.
// Define PLL_CFG_READBACK_EN to read back and compare the written divider before resetting the PLL.
module pll_dyn_cfg_ctrl
  import pll_cfg_pkg::*;
#(
  parameter int         NUM_CH         = 3,
  parameter logic [7:0] ODIV_BASE_ADDR = 8'h10,
  parameter int         RST_CYCLES     = 16,
  parameter int         LOCK_TIMEOUT   = 65535,
  parameter logic [7:0] DIV_RST_VAL    = 8'd8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_ch,
  input  logic [7:0]            cmd_div,
  output logic                  rsp_valid,
  output logic [1:0]            rsp_status,
  output logic                  busy,
  output logic [8*NUM_CH-1:0]   cfg_div,
  input  logic                  pll_lock,
  output logic                  pll_reset,
  output logic [1:0]            mdopc,
  output logic                  mdainc,
  output logic [7:0]            mdwdi,
  input  logic [7:0]            mdrdo
);

  localparam int         CNT_MAX  = (LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES;
  localparam int         CW       = $clog2(CNT_MAX + 1);
  localparam logic [3:0] CH_LIMIT = 4'(NUM_CH);

  state_t                r_state;
  logic [2:0]            r_ch;
  logic [7:0]            r_div;
  logic [CW-1:0]         r_cnt;
  logic                  r_cmd_ready;
  logic                  r_rsp_valid;
  logic [1:0]            r_status;
  logic                  r_busy;
  logic [8*NUM_CH-1:0]   r_cfg_div;
  logic                  r_pll_reset;
  logic [1:0]            r_mdopc;
  logic [7:0]            r_mdwdi;

  logic w_lock;
  logic w_bad_arg;

  sync_2ff u_lock_sync (
    .i_clk   (clk),
    .i_reset (reset),
    .i_d     (pll_lock),
    .o_q     (w_lock)
  );

  assign w_bad_arg = ({1'b0, r_ch} >= CH_LIMIT) || (r_div < DIV_MIN) || (r_div > DIV_MAX);

`ifndef PLL_CFG_READBACK_EN
  logic w_unused_mdrdo;
  assign w_unused_mdrdo = ^mdrdo;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ch        <= 3'd0;
      r_div       <= 8'd0;
      r_cnt       <= '0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_status    <= STAT_OK;
      r_busy      <= 1'b0;
      r_cfg_div   <= {NUM_CH{DIV_RST_VAL}};
      r_pll_reset <= 1'b0;
      r_mdopc     <= MD_NOP;
      r_mdwdi     <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_ch        <= cmd_ch;
            r_div       <= cmd_div;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_bad_arg) begin
            r_status    <= STAT_BAD_ARG;
            r_rsp_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_RESP;
          end else begin
            r_mdopc <= MD_SETADDR;
            r_mdwdi <= ODIV_BASE_ADDR + {5'd0, r_ch};
            r_state <= S_SETADDR;
          end
        end
        S_SETADDR: begin
          r_mdopc <= MD_WRITE;
          r_mdwdi <= r_div;
          r_state <= S_WRITE;
        end
`ifdef PLL_CFG_READBACK_EN
        S_WRITE: begin
          r_mdopc <= MD_READ;
          r_mdwdi <= 8'd0;
          r_state <= S_READ;
        end
        S_READ: begin
          r_mdopc <= MD_NOP;
          r_state <= S_CMP;
        end
        // Read data is valid the cycle after the READ opcode.
        S_CMP: begin
          if (mdrdo == r_div) begin
            r_pll_reset <= 1'b1;
            r_cnt       <= '0;
            r_state     <= S_PRST;
          end else begin
            r_status    <= STAT_RB_MISMATCH;
            r_rsp_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_RESP;
          end
        end
`else
        S_WRITE: begin
          r_mdopc     <= MD_NOP;
          r_mdwdi     <= 8'd0;
          r_pll_reset <= 1'b1;
          r_cnt       <= '0;
          r_state     <= S_PRST;
        end
`endif
        S_PRST: begin
          if (r_cnt == CW'(RST_CYCLES - 1)) begin
            r_pll_reset <= 1'b0;
            r_cnt       <= '0;
            r_state     <= S_WLOCK;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_WLOCK: begin
          if (w_lock) begin
            for (int i = 0; i < NUM_CH; i++) begin
              if (r_ch == 3'(i)) r_cfg_div[i*8 +: 8] <= r_div;
            end
            r_status    <= STAT_OK;
            r_rsp_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_RESP;
          end else if (r_cnt >= CW'(LOCK_TIMEOUT - 1)) begin
            r_status    <= STAT_LOCK_TIMEOUT;
            r_rsp_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_RESP;
          end else if (r_cnt != {CW{1'b1}}) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RESP: begin
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_status = r_status;
  assign busy       = r_busy;
  assign cfg_div    = r_cfg_div;
  assign pll_reset  = r_pll_reset;
  assign mdopc      = r_mdopc;
  assign mdainc     = 1'b0;
  assign mdwdi      = r_mdwdi;

endmodule

// File: tb/tb_pll_dyn_cfg_ctrl.sv
// Scoreboard bench for pll_dyn_cfg_ctrl with a PLL lock model and an MD register model.
module tb_pll_dyn_cfg_ctrl;

  localparam int NCH = 3;
  localparam int RST_C = 16;
  localparam int LTO = 100;
  localparam logic [1:0] EXP_OK = 2'b00, EXP_BAD = 2'b01, EXP_TO = 2'b10, EXP_RB = 2'b11;
`ifdef PLL_CFG_READBACK_EN
  localparam int RB_EXTRA = 2;
`else
  localparam int RB_EXTRA = 0;
`endif

  typedef struct packed {
    logic [1:0]  st;
    logic [23:0] cfg;
  } sb_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [2:0] cmd_ch = 3'd0;
  logic [7:0] cmd_div = 8'd0;
  logic rsp_valid;
  logic [1:0] rsp_status;
  logic busy;
  logic [23:0] cfg_div;
  logic pll_lock;
  logic pll_reset;
  logic [1:0] mdopc;
  logic mdainc;
  logic [7:0] mdwdi;
  logic [7:0] mdrdo;

  int tests = 0, fails = 0;
  int cyc = 0, acc_cyc = 0, rsp_cyc = 0, fall_cyc = 0, n_rsp = 0, prst_cnt = 0;
  bit prev_prst = 1'b0;
  bit lock_mode = 1'b1;
  int lock_delay = 0;
  int rel_cnt = 1000;
  bit rb_corrupt = 1'b0;
  logic [7:0] md_reg = 8'd0;
  logic [7:0] mcfg [NCH];
  sb_t sb [$];
  logic [9:0] trace [$];

  pll_dyn_cfg_ctrl #(.NUM_CH(NCH), .ODIV_BASE_ADDR(8'h10), .RST_CYCLES(RST_C),
                     .LOCK_TIMEOUT(LTO), .DIV_RST_VAL(8'd8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_div(cmd_div), .rsp_valid(rsp_valid), .rsp_status(rsp_status),
    .busy(busy), .cfg_div(cfg_div), .pll_lock(pll_lock), .pll_reset(pll_reset),
    .mdopc(mdopc), .mdainc(mdainc), .mdwdi(mdwdi), .mdrdo(mdrdo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // PLL model: lock drops during reset, returns lock_delay cycles after release
  always @(posedge clk) begin
    if (pll_reset) rel_cnt <= 0;
    else if (rel_cnt < 1000) rel_cnt <= rel_cnt + 1;
  end
  assign pll_lock = lock_mode && !pll_reset && (rel_cnt >= lock_delay);

  always @(posedge clk) if (mdopc == 2'b01) md_reg <= mdwdi;
  assign mdrdo = md_reg ^ {7'd0, rb_corrupt};

  function automatic logic [23:0] pack_cfg();
    return {mcfg[2], mcfg[1], mcfg[0]};
  endfunction

  always @(negedge clk) begin
    sb_t e;
    if (pll_reset) prst_cnt++;
    if (prev_prst && !pll_reset) fall_cyc = cyc;
    prev_prst = pll_reset;
    if (mdopc != 2'b00) trace.push_back({mdopc, mdwdi});
    if (rsp_valid) begin
      rsp_cyc = cyc;
      n_rsp++;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_rsp: status=%0d with no response outstanding", rsp_status);
      end else begin
        e = sb.pop_front();
        if (rsp_status !== e.st) begin
          fails++;
          $display("FAIL rsp_status: got %0d expected %0d", rsp_status, e.st);
        end
        tests++;
        if (cfg_div !== e.cfg) begin
          fails++;
          $display("FAIL cfg_div_at_rsp: got %h expected %h", cfg_div, e.cfg);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] ch, input logic [7:0] div, input logic [1:0] st, input bit push);
    sb_t e;
    int w = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL cmd_ready_wait: got %b expected 1", cmd_ready);
    end
    if (push) begin
      if (st == EXP_OK) mcfg[ch] = div;
      e.st = st;
      e.cfg = pack_cfg();
      sb.push_back(e);
    end
    prst_cnt = 0;
    trace.delete();
    cmd_valid = 1'b1; cmd_ch = ch; cmd_div = div;
    @(posedge clk); #1;
    acc_cyc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int nb, input int budget, input string tag);
    int k = 0;
    while (n_rsp == nb && k < budget) begin @(negedge clk); #1; k++; end
    tests++;
    if (n_rsp == nb) begin
      fails++;
      $display("FAIL %s_rsp_timeout: got no response expected one within %0d cycles", tag, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    tests++; if ({rsp_valid, rsp_status, busy, pll_reset} !== 5'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b expected 00000", {rsp_valid, rsp_status, busy, pll_reset}); end
    tests++; if ({mdopc, mdainc, mdwdi} !== 11'd0) begin
      fails++; $display("FAIL reset_md: got %h expected 000", {mdopc, mdainc, mdwdi}); end
    tests++; if (cfg_div !== 24'h080808) begin fails++; $display("FAIL reset_cfg: got %h expected 080808", cfg_div); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_ok();
    logic [9:0] exp_tr [$];
    logic [9:0] got;
    int nb = n_rsp;
    lock_mode = 1'b1; lock_delay = 3;
    issue(3'd1, 8'd24, EXP_OK, 1'b1);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL write_busy: got %b expected 1", busy); end
    wait_rsp(nb, 200, "write");
    exp_tr.push_back({2'b11, 8'h11});
    exp_tr.push_back({2'b01, 8'd24});
    tests++; if (trace.size() != 2 + RB_EXTRA / 2) begin
      fails++; $display("FAIL write_md_count: got %0d expected %0d", trace.size(), 2 + RB_EXTRA / 2); end
    for (int i = 0; i < 2; i++) begin
      got = (i < trace.size()) ? trace[i] : 10'h3ff;
      tests++; if (got !== exp_tr[i]) begin fails++; $display("FAIL write_md_seq%0d: got %h expected %h", i, got, exp_tr[i]); end
    end
`ifdef PLL_CFG_READBACK_EN
    got = (trace.size() > 2) ? trace[2] : 10'h3ff;
    tests++; if (got[9:8] !== 2'b10) begin fails++; $display("FAIL write_md_read: got %b expected 10", got[9:8]); end
`endif
    tests++; if (prst_cnt != RST_C) begin fails++; $display("FAIL write_prst_len: got %0d expected %0d", prst_cnt, RST_C); end
    tests++; if (rsp_cyc - acc_cyc != 3 + RST_C + 2 + 1 + 3 + RB_EXTRA) begin
      fails++; $display("FAIL write_latency: got %0d expected %0d", rsp_cyc - acc_cyc, 3 + RST_C + 2 + 1 + 3 + RB_EXTRA); end
    @(negedge clk);
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL write_ready_after: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_bad_arg();
    logic [2:0] chs [3] = '{3'd3, 3'd0, 3'd2};
    logic [7:0] divs [3] = '{8'd24, 8'd1, 8'd129};
    for (int i = 0; i < 3; i++) begin
      int nb = n_rsp;
      issue(chs[i], divs[i], EXP_BAD, 1'b1);
      wait_rsp(nb, 20, "bad");
      tests++; if (rsp_cyc - acc_cyc != 1) begin fails++; $display("FAIL bad%0d_latency: got %0d expected 1", i, rsp_cyc - acc_cyc); end
      tests++; if (trace.size() != 0 || prst_cnt != 0) begin
        fails++; $display("FAIL bad%0d_activity: got md=%0d prst=%0d expected 0 0", i, trace.size(), prst_cnt); end
    end
  endtask

  task automatic test_timeout();
    int nb = n_rsp;
    lock_mode = 1'b0;
    issue(3'd0, 8'd50, EXP_TO, 1'b1);
    wait_rsp(nb, 300, "timeout");
    tests++; if (rsp_cyc - fall_cyc != LTO) begin
      fails++; $display("FAIL timeout_wlock_len: got %0d expected %0d", rsp_cyc - fall_cyc, LTO); end
    lock_mode = 1'b1;
  endtask

  task automatic test_readback();
`ifdef PLL_CFG_READBACK_EN
    int nb = n_rsp;
    rb_corrupt = 1'b1;
    issue(3'd2, 8'd40, EXP_RB, 1'b1);
    wait_rsp(nb, 50, "readback");
    tests++; if (prst_cnt != 0) begin fails++; $display("FAIL rb_no_prst: got %0d expected 0", prst_cnt); end
    tests++; if (rsp_cyc - acc_cyc != 5) begin fails++; $display("FAIL rb_latency: got %0d expected 5", rsp_cyc - acc_cyc); end
    rb_corrupt = 1'b0;
`endif
  endtask

  task automatic test_busy_ignore();
    int nb = n_rsp;
    lock_delay = 5;
    issue(3'd0, 8'd60, EXP_OK, 1'b1);
    repeat (20) @(negedge clk);
    cmd_valid = 1'b1; cmd_ch = 3'd2; cmd_div = 8'd99;
    repeat (2) @(negedge clk);
    cmd_valid = 1'b0;
    wait_rsp(nb, 100, "busy");
    tests++; if (rsp_cyc - acc_cyc != 22 + 5 + RB_EXTRA) begin
      fails++; $display("FAIL busy_latency: got %0d expected %0d", rsp_cyc - acc_cyc, 22 + 5 + RB_EXTRA); end
    repeat (40) @(negedge clk);
    tests++; if (n_rsp != nb + 1) begin fails++; $display("FAIL busy_rsp_count: got %0d expected 1", n_rsp - nb); end
  endtask

  task automatic test_back_to_back();
    int nb = n_rsp;
    lock_delay = 0;
    issue(3'd0, 8'd50, EXP_OK, 1'b1);
    wait_rsp(nb, 100, "b2b0");
    issue(3'd2, 8'd10, EXP_OK, 1'b1);
    wait_rsp(nb + 1, 100, "b2b1");
    tests++; if (cfg_div !== {8'd10, 8'd24, 8'd50}) begin
      fails++; $display("FAIL b2b_cfg: got %h expected %h", cfg_div, {8'd10, 8'd24, 8'd50}); end
  endtask

  task automatic test_reset_mid_prst();
    int nb;
    lock_delay = 2;
    issue(3'd1, 8'd77, EXP_OK, 1'b0);
    repeat (8) @(negedge clk);
    tests++; if (pll_reset !== 1'b1) begin fails++; $display("FAIL mid_prst_high: got %b expected 1", pll_reset); end
    #2 reset = 1'b1;
    #1;
    tests++; if (pll_reset !== 1'b0) begin fails++; $display("FAIL mid_prst_async_drop: got %b expected 0", pll_reset); end
    tests++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL mid_prst_ctrl: got ready=%b busy=%b expected 1 0", cmd_ready, busy); end
    tests++; if (cfg_div !== 24'h080808) begin fails++; $display("FAIL mid_prst_cfg: got %h expected 080808", cfg_div); end
    for (int i = 0; i < NCH; i++) mcfg[i] = 8'd8;
    @(negedge clk);
    reset = 1'b0;
    nb = n_rsp;
    issue(3'd1, 8'd77, EXP_OK, 1'b1);
    wait_rsp(nb, 100, "after_reset");
    tests++; if (cfg_div !== 24'h084d08) begin fails++; $display("FAIL after_reset_cfg: got %h expected 084d08", cfg_div); end
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) mcfg[i] = 8'd8;
    test_reset();
    test_write_ok();
    test_bad_arg();
    test_timeout();
    test_readback();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_prst();
    repeat (5) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL sb_drain: got %0d outstanding expected 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
